// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, next-PC
// select encodings, the NOP instruction and the default reset PC.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam logic [1:0]  PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0]  PC_SRC_TARGET = 2'b01;
  localparam logic [1:0]  PC_SRC_JALR   = 2'b10;
  localparam logic [1:0]  PC_SRC_RSVD   = 2'b11;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A fetch address is legal only when it is word aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus. The fetch unit is the master;
// the instruction memory (or the testbench) is the slave.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection. Produces pc+4 (wrapping mod 2^32), the
// selected next PC with the JALR low bit cleared, and an alignment flag.
module next_pc_mux
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_target,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        next_pc_aligned
);

  logic [31:0] jalr_target_s;

  // Sequential increment plus JALR target with bit 0 forced to zero.
  always_comb begin
    pc_plus4      = pc + 32'd4;
    jalr_target_s = alu_result & 32'hFFFF_FFFE;
  end

  // Select the next PC; the reserved encoding falls back to pc+4.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SRC_PLUS4:  next_pc = pc_plus4;
      PC_SRC_TARGET: next_pc = pc_target;
      PC_SRC_JALR:   next_pc = jalr_target_s;
      PC_SRC_RSVD:   next_pc = pc_plus4;
      default:       next_pc = pc_plus4;
    endcase
    next_pc_aligned = is_aligned(next_pc);
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit. Requests one word at
// a time, holds it for decode until retired, then steps the PC. A retire
// towards a misaligned target halts fetching until reset.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         pc_src,
  input  logic [31:0]        pc_target,
  input  logic [31:0]        alu_result,
  fetch_unit_if.master       imem,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               misalign_err
);

  fetch_state_t state_r;
  fetch_state_t state_next_s;

  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic        misalign_err_r;
  logic        req_valid_r;
  logic        instr_valid_r;

  logic [31:0] next_pc_s;
  logic        next_pc_aligned_s;
  logic        retire_s;
  logic        rsp_take_s;

  next_pc_mux u_next_pc_mux (
    .pc              (pc_r),
    .pc_src          (pc_src),
    .pc_target       (pc_target),
    .alu_result      (alu_result),
    .pc_plus4        (pc_plus4),
    .next_pc         (next_pc_s),
    .next_pc_aligned (next_pc_aligned_s)
  );

  // Handshake qualifiers; the response is only looked at while waiting.
  always_comb begin
    retire_s   = (state_r == VALID) && instr_ready;
    rsp_take_s = (state_r == WAIT) && imem.imem_rsp_valid;
  end

  // Next-state logic for the fetch FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        state_next_s = REQ;
      end
      REQ: begin
        if (imem.imem_req_ready) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_next_s = VALID;
        end else begin
          state_next_s = WAIT;
        end
      end
      VALID: begin
        if (instr_ready) begin
          if (next_pc_aligned_s) begin
            state_next_s = REQ;
          end else begin
            state_next_s = HALT;
          end
        end else begin
          state_next_s = VALID;
        end
      end
      HALT: begin
        state_next_s = HALT;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, PC, instruction and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      pc_r           <= RESET_PC;
      instr_r        <= NOP_INSTR;
      misalign_err_r <= 1'b0;
      req_valid_r    <= 1'b0;
      instr_valid_r  <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      req_valid_r   <= (state_next_s == REQ);
      instr_valid_r <= (state_next_s == VALID);
      if (rsp_take_s) begin
        instr_r <= imem.imem_rsp_data;
      end
      if (retire_s && next_pc_aligned_s) begin
        pc_r <= next_pc_s;
      end
      if (retire_s && !next_pc_aligned_s) begin
        misalign_err_r <= 1'b1;
      end
    end
  end

  // Drive the bus and decode-side outputs from registers.
  always_comb begin
    imem.imem_req_valid = req_valid_r;
    imem.imem_addr      = pc_r;
    instr_valid         = instr_valid_r;
    instr               = instr_r;
    pc                  = pc_r;
    misalign_err        = misalign_err_r;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset state, fetch/retire flow,
// branch/jalr targets, stalls, misalignment halt, reset during WAIT and
// PC wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .alu_result   (alu_result),
    .imem         (imem),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, accept it, respond after 'delay' idle cycles.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int delay);
    int n = 0;
    while (imem.imem_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
    check("imem_addr", imem.imem_addr, addr);
    imem.imem_req_ready = 1'b1;
    step();
    imem.imem_req_ready = 1'b0;
    check("req_drop_in_wait", {31'd0, imem.imem_req_valid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      step();
    end
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = data;
    step();
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0000_0000;
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, data);
    check("pc", pc, addr);
  endtask

  task automatic retire(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    pc_src      = src;
    pc_target   = tgt;
    alu_result  = alu;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    pc_src      = 2'b01;
    pc_target   = 32'hDEAD_BEEC;
    alu_result  = 32'hCAFE_F00C;
  endtask

  initial begin
    reset               = 1'b1;
    pc_src              = 2'b00;
    pc_target           = 32'h0000_0000;
    alu_result          = 32'h0000_0000;
    instr_ready         = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0000_0000;
    step();
    step();

    // Reset values
    check("rst_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    reset = 1'b0;

    // First fetch, 1-cycle response latency
    fetch(32'h0000_0000, 32'h0050_0093, 0);
    check("pc_plus4_first", pc_plus4, 32'h0000_0004);

    // Sequential retire
    retire(2'b00, 32'h0000_0800, 32'h0000_0000);
    check("seq_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
    check("seq_addr", imem.imem_addr, 32'h0000_0004);
    check("seq_instr_valid", {31'd0, instr_valid}, 32'd0);

    // Request stall for 5 cycles; a stray response in REQ must be ignored
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'hDEAD_DEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
      check("stall_addr", imem.imem_addr, 32'h0000_0004);
    end
    imem.imem_rsp_valid = 1'b0;
    check("stall_instr_kept", instr, 32'h0050_0093);
    fetch(32'h0000_0004, 32'h1111_1113, 2);

    // Decode stall for 3 cycles with changing select inputs
    for (int i = 0; i < 3; i++) begin
      pc_src    = 2'b01;
      pc_target = 32'h0000_0040 + 32'(i);
      step();
      check("hold_instr_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, 32'h1111_1113);
      check("hold_pc", pc, 32'h0000_0004);
    end

    // Branch target
    retire(2'b01, 32'h0000_0100, 32'h0000_0000);
    check("br_addr", imem.imem_addr, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h2222_2223, 1);

    // JALR with low bit cleared
    retire(2'b10, 32'h0000_0000, 32'h0000_0201);
    check("jalr_addr", imem.imem_addr, 32'h0000_0200);
    check("jalr_no_err", {31'd0, misalign_err}, 32'd0);
    fetch(32'h0000_0200, 32'h3333_3333, 0);

    // JALR to a halfword-aligned target halts
    retire(2'b10, 32'h0000_0000, 32'h0000_0206);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_pc_hold", pc, 32'h0000_0200);
    for (int i = 0; i < 5; i++) begin
      imem.imem_req_ready = 1'b1;
      instr_ready = 1'b1;
      step();
      check("halt_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
      check("halt_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_err", {31'd0, misalign_err}, 32'd1);
    end
    imem.imem_req_ready = 1'b0;
    instr_ready = 1'b0;

    // Reset leaves HALT
    reset = 1'b1;
    step();
    check("rst2_err", {31'd0, misalign_err}, 32'd0);
    check("rst2_pc", pc, 32'h0000_0000);
    reset = 1'b0;
    step();
    check("rst2_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);

    // Reset while WAIT; late response must be ignored
    imem.imem_req_ready = 1'b1;
    step();
    imem.imem_req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'hBAD0_0BAD;
    step();
    imem.imem_rsp_valid = 1'b0;
    check("late_rsp_instr", instr, 32'h0000_0013);
    check("late_rsp_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("late_rsp_refetch", {31'd0, imem.imem_req_valid}, 32'd1);
    check("late_rsp_addr", imem.imem_addr, 32'h0000_0000);

    // PC wrap-around
    fetch(32'h0000_0000, 32'h0000_0013, 0);
    retire(2'b01, 32'hFFFF_FFFC, 32'h0000_0000);
    fetch(32'hFFFF_FFFC, 32'h4444_4443, 0);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    retire(2'b00, 32'h0000_0000, 32'h0000_0000);
    check("wrap_addr", imem.imem_addr, 32'h0000_0000);

    // Reserved select behaves as pc+4
    fetch(32'h0000_0000, 32'h5555_5553, 0);
    retire(2'b11, 32'h0000_0700, 32'h0000_0900);
    check("rsvd_addr", imem.imem_addr, 32'h0000_0004);
    check("rsvd_no_err", {31'd0, misalign_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
